// File: rtl/taus113_pkg.sv
// Shared constants, state encoding and per-component helpers for the
// four-component Tausworthe (taus113) generator.
package taus113_pkg;

  localparam logic [31:0] MASK1 = 32'hFFFF_FFFE;
  localparam logic [31:0] MASK2 = 32'hFFFF_FFF8;
  localparam logic [31:0] MASK3 = 32'hFFFF_FFF0;
  localparam logic [31:0] MASK4 = 32'hFFFF_FF80;

  // Shift amounts per component: feedback pre-shift, feedback right shift,
  // masked-state left shift.
  localparam int unsigned SH1_A = 6;
  localparam int unsigned SH1_B = 13;
  localparam int unsigned SH1_C = 18;
  localparam int unsigned SH2_A = 2;
  localparam int unsigned SH2_B = 27;
  localparam int unsigned SH2_C = 2;
  localparam int unsigned SH3_A = 13;
  localparam int unsigned SH3_B = 21;
  localparam int unsigned SH3_C = 7;
  localparam int unsigned SH4_A = 3;
  localparam int unsigned SH4_B = 12;
  localparam int unsigned SH4_C = 13;

  localparam logic [31:0] MIN1 = 32'd2;
  localparam logic [31:0] MIN2 = 32'd8;
  localparam logic [31:0] MIN3 = 32'd16;
  localparam logic [31:0] MIN4 = 32'd128;

  typedef enum logic [1:0] {
    ST_WARMUP,
    ST_LOAD,
    ST_RUN
  } state_t;

  // Components below their minimum would degenerate; lift them above it.
  function automatic logic [31:0] seed_comp(input logic [31:0] s,
                                            input logic [31:0] min_v);
    return (s < min_v) ? s + min_v : s;
  endfunction

  function automatic logic [31:0] step_comp(input logic [31:0] z,
                                            input logic [31:0] mask,
                                            input int unsigned sa,
                                            input int unsigned sb,
                                            input int unsigned sc);
    return ((z & mask) << sc) ^ (((z << sa) ^ z) >> sb);
  endfunction

endpackage

// File: rtl/taus113_step.sv
// Combinational single step of all four taus113 components.
module taus113_step
  import taus113_pkg::*;
(
  input  logic [31:0] z1,
  input  logic [31:0] z2,
  input  logic [31:0] z3,
  input  logic [31:0] z4,
  output logic [31:0] n1,
  output logic [31:0] n2,
  output logic [31:0] n3,
  output logic [31:0] n4
);

  assign n1 = step_comp(z1, MASK1, SH1_A, SH1_B, SH1_C);
  assign n2 = step_comp(z2, MASK2, SH2_A, SH2_B, SH2_C);
  assign n3 = step_comp(z3, MASK3, SH3_A, SH3_B, SH3_C);
  assign n4 = step_comp(z4, MASK4, SH4_A, SH4_B, SH4_C);

endmodule

// File: rtl/taus113_gen.sv
// taus113 random generator with warm-up after seeding, range scaling by
// multiply-high, and a valid/ready output register.
module taus113_gen
  import taus113_pkg::*;
#(
  parameter int unsigned OUT_W        = 16,
  parameter int unsigned WARMUP       = 8,
  parameter logic [31:0] DEFAULT_SEED = 32'd987654321
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [31:0]      seed_i,
  input  logic [OUT_W-1:0] range_i,
  input  logic             rnd_ready,
  output logic             rnd_valid,
  output logic [OUT_W-1:0] rnd_o,
  output logic [31:0]      raw_o,
  output logic             busy
);

  localparam int unsigned PW        = 32 + OUT_W;
  localparam logic [7:0]  WARM_INIT = 8'(WARMUP);

  state_t      state;
  logic [7:0]  warm_cnt;
  logic [31:0] z1, z2, z3, z4;
  logic [31:0] n1, n2, n3, n4;
  logic [PW-1:0]    prod;
  logic [OUT_W-1:0] ranged;

  taus113_step u_step (
    .z1(z1),
    .z2(z2),
    .z3(z3),
    .z4(z4),
    .n1(n1),
    .n2(n2),
    .n3(n3),
    .n4(n4)
  );

  assign raw_o = z1 ^ z2 ^ z3 ^ z4;
  assign prod  = PW'(raw_o) * PW'(range_i);

  always_comb begin
    ranged = raw_o[31:32-OUT_W];
    if (range_i != '0) ranged = prod[PW-1:32];
  end

  // The last warm-up step moves straight to LOAD (and a zero warm-up count
  // skips WARMUP after seeding), so the first value is valid WARMUP+1
  // cycles after the seeding edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      z1        <= seed_comp(DEFAULT_SEED, MIN1);
      z2        <= seed_comp(DEFAULT_SEED, MIN2);
      z3        <= seed_comp(DEFAULT_SEED, MIN3);
      z4        <= seed_comp(DEFAULT_SEED, MIN4);
      warm_cnt  <= WARM_INIT;
      state     <= ST_WARMUP;
      rnd_valid <= 1'b0;
      rnd_o     <= '0;
      busy      <= 1'b1;
    end else if (seed_load) begin
      z1        <= seed_comp(seed_i, MIN1);
      z2        <= seed_comp(seed_i, MIN2);
      z3        <= seed_comp(seed_i, MIN3);
      z4        <= seed_comp(seed_i, MIN4);
      warm_cnt  <= WARM_INIT;
      state     <= (WARMUP == 0) ? ST_LOAD : ST_WARMUP;
      rnd_valid <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state)
        ST_WARMUP: begin
          if (warm_cnt != 8'd0) begin
            z1       <= n1;
            z2       <= n2;
            z3       <= n3;
            z4       <= n4;
            warm_cnt <= warm_cnt - 8'd1;
            if (warm_cnt == 8'd1) state <= ST_LOAD;
          end else begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          rnd_o     <= ranged;
          z1        <= n1;
          z2        <= n2;
          z3        <= n3;
          z4        <= n4;
          rnd_valid <= 1'b1;
          state     <= ST_RUN;
          busy      <= 1'b0;
        end
        ST_RUN: begin
          if (rnd_valid && rnd_ready) begin
            rnd_o <= ranged;
            z1    <= n1;
            z2    <= n2;
            z3    <= n3;
            z4    <= n4;
          end
        end
        default: begin
          state     <= ST_WARMUP;
          warm_cnt  <= WARM_INIT;
          rnd_valid <= 1'b0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_taus113_gen.sv
// Directed self-checking bench for taus113_gen against a software taus113 model.
module tb_taus113_gen;

  localparam int unsigned OW    = 16;
  localparam int unsigned WU    = 3;
  localparam logic [31:0] DSEED = 32'd987654321;

  logic          clk;
  logic          reset;
  logic          seed_load;
  logic [31:0]   seed_i;
  logic [OW-1:0] range_i;
  logic          rnd_ready;
  logic          rnd_valid;
  logic [OW-1:0] rnd_o;
  logic [31:0]   raw_o;
  logic          busy;

  taus113_gen #(
    .OUT_W(OW),
    .WARMUP(WU),
    .DEFAULT_SEED(DSEED)
  ) dut (
    .clk(clk),
    .reset(reset),
    .seed_load(seed_load),
    .seed_i(seed_i),
    .range_i(range_i),
    .rnd_ready(rnd_ready),
    .rnd_valid(rnd_valid),
    .rnd_o(rnd_o),
    .raw_o(raw_o),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0]   m1, m2, m3, m4;
  logic [OW-1:0] exp_rnd;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] m_raw();
    return m1 ^ m2 ^ m3 ^ m4;
  endfunction

  task automatic m_seed(input logic [31:0] s);
    m1 = (s < 32'd2)   ? s + 32'd2   : s;
    m2 = (s < 32'd8)   ? s + 32'd8   : s;
    m3 = (s < 32'd16)  ? s + 32'd16  : s;
    m4 = (s < 32'd128) ? s + 32'd128 : s;
  endtask

  task automatic m_step();
    logic [31:0] t1, t2, t3, t4;
    t1 = ((m1 & 32'hFFFFFFFE) << 18) ^ (((m1 << 6) ^ m1) >> 13);
    t2 = ((m2 & 32'hFFFFFFF8) << 2) ^ (((m2 << 2) ^ m2) >> 27);
    t3 = ((m3 & 32'hFFFFFFF0) << 7) ^ (((m3 << 13) ^ m3) >> 21);
    t4 = ((m4 & 32'hFFFFFF80) << 13) ^ (((m4 << 3) ^ m4) >> 12);
    m1 = t1; m2 = t2; m3 = t3; m4 = t4;
  endtask

  function automatic logic [OW-1:0] m_range(input logic [31:0] x, input logic [OW-1:0] r);
    logic [63:0] p;
    if (r == '0) return x[31:32-OW];
    p = {32'b0, x} * {48'b0, r};
    return p[32+OW-1:32];
  endfunction

  // One load or handshake: present ranged(raw), then advance.
  task automatic m_event(input logic [OW-1:0] r);
    exp_rnd = m_range(m_raw(), r);
    m_step();
  endtask

  task automatic m_start(input logic [31:0] s);
    m_seed(s);
    repeat (WU) m_step();
  endtask

  task automatic do_seed(input logic [31:0] s, input logic rdy);
    seed_i    = s;
    seed_load = 1'b1;
    rnd_ready = rdy;
    tick();
    seed_load = 1'b0;
  endtask

  // Counts edges until rnd_valid; the first value is then checked.
  task automatic wait_first(input string tag);
    int n;
    n = 0;
    while (!rnd_valid && n < 64) begin
      tick();
      n++;
    end
    check_val({tag, "_latency"}, 64'(n), 64'(WU + 1));
    m_event(range_i);
    check_val({tag, "_first_rnd"}, 64'(rnd_o), 64'(exp_rnd));
    check_val({tag, "_first_raw"}, 64'(raw_o), 64'(m_raw()));
  endtask

  task automatic stream(input string tag, input int n, input int stall_mod);
    logic r;
    for (int i = 0; i < n; i++) begin
      r = (stall_mod == 0) || ((i % stall_mod) != 0);
      rnd_ready = r;
      tick();
      if (r) m_event(range_i);
      check_val({tag, "_rnd"}, 64'(rnd_o), 64'(exp_rnd));
      check_val({tag, "_raw"}, 64'(raw_o), 64'(m_raw()));
      check_val({tag, "_valid"}, 64'(rnd_valid), 64'd1);
    end
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_valid"}, 64'(rnd_valid), 64'd0);
    check_val({tag, "_rnd"}, 64'(rnd_o), 64'd0);
    check_val({tag, "_busy"}, 64'(busy), 64'd1);
    m_seed(DSEED);
    check_val({tag, "_raw"}, 64'(raw_o), 64'(m_raw()));
  endtask

  initial begin
    logic [5:0] seen;
    reset     = 1'b1;
    seed_load = 1'b0;
    seed_i    = '0;
    range_i   = '0;
    rnd_ready = 1'b0;
    tick();
    tick();
    check_reset_state("por");

    reset     = 1'b0;
    rnd_ready = 1'b1;
    m_start(DSEED);
    wait_first("por");
    stream("por", 20, 0);

    // Seed 0: every component lifted to its minimum, raw = 2^8^16^128.
    do_seed(32'd0, 1'b1);
    check_val("seed0_raw", 64'(raw_o), 64'd154);
    check_val("seed0_valid", 64'(rnd_valid), 64'd0);
    check_val("seed0_busy", 64'(busy), 64'd1);
    m_start(32'd0);
    wait_first("seed0");
    stream("seed0", 10, 0);

    // Seed 5: components 5,13,21,133.
    do_seed(32'd5, 1'b1);
    check_val("seed5_raw", 64'(raw_o), 64'd152);
    m_start(32'd5);
    wait_first("seed5");
    stream("seed5", 1000, 0);
    stream("seed5_gap", 30, 3);

    // Stall: output and state frozen; range_i changes are not sampled.
    rnd_ready = 1'b0;
    range_i   = 16'd6;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_val("stall_rnd", 64'(rnd_o), 64'(exp_rnd));
      check_val("stall_raw", 64'(raw_o), 64'(m_raw()));
    end
    range_i = '0;
    stream("resume", 10, 0);

    range_i = 16'd6;
    seen    = '0;
    for (int i = 0; i < 10000; i++) begin
      rnd_ready = 1'b1;
      tick();
      m_event(range_i);
      check_val("r6_rnd", 64'(rnd_o), 64'(exp_rnd));
      check_val("r6_bound", 64'(rnd_o < 16'd6), 64'd1);
      if (rnd_o < 16'd6) seen[rnd_o[2:0]] = 1'b1;
    end
    check_val("r6_all_seen", 64'(seen), 64'h3F);

    range_i = 16'd1;
    stream("r1", 5, 0);
    check_val("r1_zero", 64'(rnd_o), 64'd0);
    range_i = 16'hFFFF;
    stream("rmax", 5, 0);
    range_i = '0;

    // Reseed coincident with a handshake, then mid-stream without one.
    do_seed(32'd5, 1'b1);
    check_val("seedhs_valid", 64'(rnd_valid), 64'd0);
    m_start(32'd5);
    wait_first("seedhs");
    stream("seedhs", 10, 0);
    do_seed(32'hDEADBEEF, 1'b0);
    check_val("seedmid_valid", 64'(rnd_valid), 64'd0);
    m_start(32'hDEADBEEF);
    wait_first("seedmid");
    stream("seedmid", 10, 2);

    // Reset in RUN, with a competing seed_load that must lose.
    reset     = 1'b1;
    seed_load = 1'b1;
    seed_i    = 32'd5;
    rnd_ready = 1'b1;
    tick();
    reset     = 1'b0;
    seed_load = 1'b0;
    check_reset_state("rst_run");
    m_start(DSEED);
    wait_first("rst_run");
    stream("rst_run", 10, 0);

    // Reset during warm-up.
    do_seed(32'd77, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("rst_warm");
    m_start(DSEED);
    wait_first("rst_warm");
    stream("rst_warm", 10, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
